adc_sample_writer: RTL and testbench

Decimating sample writer between `adc_data_capture` and the ADC write-only port of `RAM`. On a programmable sample tick it latches the EMG and ECG samples and averages 2^AVG_LOG2 consecutive samples per channel. Each average is written into that channel's circular buffer region of data RAM, one word per channel. It exposes the current write index and a frame-complete pulse, so the CPU and VGA know which region of the buffer is stable.

---
 rtl/adc_sample_writer.sv | 138 +++++++++++++
 tb/tb_adc_sample_writer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_writer.sv
// Decimating EMG/ECG sample writer feeding the RAM ADC write port.
// Averages 2^AVG_LOG2 ticks per channel into two circular RAM rings.
module adc_sample_writer #(
  parameter int          SAMPLE_INTERVAL = 125000,
  parameter int          AVG_LOG2        = 2,
  parameter int          DEPTH           = 640,
  parameter logic [11:0] EMG_BASE        = 12'h400,
  parameter logic [11:0] ECG_BASE        = 12'h800
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] emg_in,
  input  logic [15:0] ecg_in,
  output logic        adc_wEn,
  output logic [11:0] adc_addr,
  output logic [31:0] adc_dataIn,
  output logic [9:0]  wr_index,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int CW = $clog2(SAMPLE_INTERVAL);
  localparam int AW = 12 + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;

  localparam logic [CW-1:0] TICK_LAST =
    CW'(SAMPLE_INTERVAL - 1);
  localparam logic [NW-1:0] RAW_LAST =
    NW'((1 << AVG_LOG2) - 1);
  localparam logic [9:0] IDX_LAST =
    10'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_EMG,
    WR_ECG
  } state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic [NW-1:0] raw_cnt;
  logic [AW-1:0] acc_emg;
  logic [AW-1:0] acc_ecg;
  logic [11:0]   hold_ecg;

  logic          tick;
  logic          blk_done;
  logic [AW-1:0] sum_emg;
  logic [AW-1:0] sum_ecg;
  logic [11:0]   avg_emg;
  logic [11:0]   avg_ecg;
  logic          unused_lsb;

  assign tick     = enable && (tick_cnt == TICK_LAST);
  assign blk_done = tick && (raw_cnt == RAW_LAST);

  assign sum_emg = acc_emg + AW'(emg_in[15:4]);
  assign sum_ecg = acc_ecg + AW'(ecg_in[15:4]);
  assign avg_emg = sum_emg[AW-1:AVG_LOG2];
  assign avg_ecg = sum_ecg[AW-1:AVG_LOG2];

  assign unused_lsb = ^{emg_in[3:0], ecg_in[3:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      raw_cnt  <= '0;
      acc_emg  <= '0;
      acc_ecg  <= '0;
      hold_ecg <= '0;
    end else if (!enable) begin
      tick_cnt <= '0;
      raw_cnt  <= '0;
      acc_emg  <= '0;
      acc_ecg  <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (blk_done) begin
        raw_cnt  <= '0;
        acc_emg  <= '0;
        acc_ecg  <= '0;
        hold_ecg <= avg_ecg;
      end else if (tick) begin
        raw_cnt <= raw_cnt + 1'b1;
        acc_emg <= sum_emg;
        acc_ecg <= sum_ecg;
      end
    end
  end

  // EMG data goes straight to the port; ECG waits in hold_ecg
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      adc_wEn     <= 1'b0;
      adc_addr    <= '0;
      adc_dataIn  <= '0;
      wr_index    <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (blk_done) begin
            state      <= WR_EMG;
            adc_wEn    <= 1'b1;
            adc_addr   <= EMG_BASE + {2'b00, wr_index};
            adc_dataIn <= {20'd0, avg_emg};
          end
        end
        WR_EMG: begin
          state      <= WR_ECG;
          adc_wEn    <= 1'b1;
          adc_addr   <= ECG_BASE + {2'b00, wr_index};
          adc_dataIn <= {20'd0, hold_ecg};
        end
        WR_ECG: begin
          state   <= IDLE;
          adc_wEn <= 1'b0;
          if (wr_index == IDX_LAST) begin
            wr_index    <= '0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
          end else begin
            wr_index <= wr_index + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          adc_wEn <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_writer.sv
// Directed bench for adc_sample_writer.
// Small ring, 4-clock tick, 4-sample average.
module tb_adc_sample_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] emg_in = '0;
  logic [15:0] ecg_in = '0;
  logic        adc_wEn;
  logic [11:0] adc_addr;
  logic [31:0] adc_dataIn;
  logic [9:0]  wr_index;
  logic        frame_done;
  logic [15:0] frame_count;

  adc_sample_writer #(
    .SAMPLE_INTERVAL(4),
    .AVG_LOG2(2),
    .DEPTH(4),
    .EMG_BASE(12'h400),
    .ECG_BASE(12'h800)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .emg_in(emg_in),
    .ecg_in(ecg_in),
    .adc_wEn(adc_wEn),
    .adc_addr(adc_addr),
    .adc_dataIn(adc_dataIn),
    .wr_index(wr_index),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [11:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          fd_n = 0;
  int          fd_cyc = 0;
  logic [15:0] fd_fc = '0;
  logic [9:0]  fd_idx = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (adc_wEn === 1'b1) begin
      wa.push_back(adc_addr);
      wd.push_back(adc_dataIn);
      wc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_n++;
      fd_cyc = cyc;
      fd_fc  = frame_count;
      fd_idx = wr_index;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic feed(input logic [15:0] e,
                      input logic [15:0] c);
    emg_in = e;
    ecg_in = c;
    repeat (4) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drain();
    enable = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
    wc.delete();
    fd_n = 0;
  endtask

  task automatic rst_pulse();
    enable = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_wen", adc_wEn, 0);
    chk("rst_addr", adc_addr, 0);
    chk("rst_data", adc_dataIn, 0);
    chk("rst_idx", wr_index, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_fc", frame_count, 0);
    reset = 1'b1;
    repeat (100) @(negedge clock);
    chk("idle_nwr", wa.size(), 0);
    chk("idle_wen", adc_wEn, 0);
    chk("idle_addr", adc_addr, 0);
    chk("idle_data", adc_dataIn, 0);
    chk("idle_idx", wr_index, 0);
    chk("idle_fc", frame_count, 0);

    enable = 1'b1;
    repeat (4) feed(16'h1230, 16'hABC0);
    chk("c_e_wen", adc_wEn, 1);
    chk("c_e_addr", adc_addr, 12'h400);
    chk("c_e_data", adc_dataIn, 32'h123);
    chk("c_e_idx", wr_index, 0);
    @(negedge clock);
    chk("c_c_wen", adc_wEn, 1);
    chk("c_c_addr", adc_addr, 12'h800);
    chk("c_c_data", adc_dataIn, 32'hABC);
    chk("c_c_idx", wr_index, 0);
    @(negedge clock);
    chk("c_i_wen", adc_wEn, 0);
    chk("c_i_idx", wr_index, 1);
    chk("c_i_addr", adc_addr, 12'h800);
    chk("c_i_data", adc_dataIn, 32'hABC);
    enable = 1'b0;
    @(negedge clock);
    clr();

    enable = 1'b1;
    feed(16'h000F, 16'hFFF0);
    feed(16'h0040, 16'hFFFF);
    feed(16'h0080, 16'hFFF0);
    feed(16'h00C0, 16'hFFF0);
    feed(16'hFFF0, 16'h0010);
    repeat (3) feed(16'hFFFF, 16'h0000);
    drain();
    chk("avg_nwr", wa.size(), 4);
    chk("avg_a0", wa[0], 12'h401);
    chk("avg_d0", wd[0], 32'h6);
    chk("avg_a1", wa[1], 12'h801);
    chk("avg_d1", wd[1], 32'hFFF);
    chk("avg_a2", wa[2], 12'h402);
    chk("avg_d2", wd[2], 32'hFFF);
    chk("avg_a3", wa[3], 12'h802);
    chk("avg_d3", wd[3], 32'h0);
    clr();

    enable = 1'b1;
    repeat (4) feed(16'h5550, 16'h6660);
    chk("mp_wen", adc_wEn, 1);
    chk("mp_addr", adc_addr, 12'h403);
    #2;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    chk("mp_async", adc_wEn, 0);
    chk("mp_aaddr", adc_addr, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    enable = 1'b1;
    repeat (4) feed(16'h7770, 16'h8880);
    drain();
    chk("mp_nwr", wa.size(), 3);
    chk("mp_a0", wa[0], 12'h403);
    chk("mp_d0", wd[0], 32'h555);
    chk("mp_a1", wa[1], 12'h400);
    chk("mp_d1", wd[1], 32'h777);
    chk("mp_a2", wa[2], 12'h800);
    chk("mp_d2", wd[2], 32'h888);

    rst_pulse();
    clr();
    enable = 1'b1;
    repeat (20) feed(16'h0210, 16'h0320);
    drain();
    chk("wr_nwr", wa.size(), 10);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wr_ea%0d", i), wa[2*i],
          32'h400 + (i % 4));
      chk($sformatf("wr_ca%0d", i), wa[2*i+1],
          32'h800 + (i % 4));
    end
    chk("wr_fd_n", fd_n, 1);
    chk("wr_fd_cyc", fd_cyc, wc[7] + 1);
    chk("wr_fd_fc", fd_fc, 1);
    chk("wr_fd_idx", fd_idx, 0);
    chk("wr_idx", wr_index, 1);
    chk("wr_fc", frame_count, 1);
    clr();

    enable = 1'b1;
    repeat (2) feed(16'hFFF0, 16'hFFF0);
    enable = 1'b0;
    repeat (20) @(negedge clock);
    chk("ed_nwr0", wa.size(), 0);
    chk("ed_idx0", wr_index, 1);
    enable = 1'b1;
    repeat (4) feed(16'h0080, 16'h0030);
    drain();
    chk("ed_nwr", wa.size(), 2);
    chk("ed_a0", wa[0], 12'h401);
    chk("ed_d0", wd[0], 32'h8);
    chk("ed_a1", wa[1], 12'h801);
    chk("ed_d1", wd[1], 32'h3);
    chk("ed_idx", wr_index, 2);
    chk("ed_fc", frame_count, 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
